// File: rtl/tx_token_arbiter_if.sv
// Transmitter launch handshake between the token arbiter and the serial transmitter.
`timescale 1ns/1ps
interface tx_token_arbiter_if #(
    parameter int DATA_W = 55
);
    logic [DATA_W-1:0] TX_Data;
    logic              TX_Data_Valid;
    logic              TX_Ready;

    modport master (output TX_Data, output TX_Data_Valid, input TX_Ready);
    modport slave  (input TX_Data, input TX_Data_Valid, output TX_Ready);
endinterface

// File: rtl/tx_token_arbiter.sv
// Round-robin arbiter sharing one serial transmitter among NREQ requesters
// while this node holds the ring token; releases it after BURST packets or when idle.
`timescale 1ns/1ps
module tx_token_arbiter #(
    parameter int NREQ       = 4,
    parameter int DATA_W     = 55,
    parameter int BURST      = 4,
    parameter int INIT_TOKEN = 0
) (
    input  logic                   Clk_S,
    input  logic                   Rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        req_grant,
    output logic [NREQ-1:0]        req_done,
    input  logic                   token_in,
    output logic                   token_out,
    output logic                   token_dup,
    tx_token_arbiter_if.master     tx
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREQ - 1);
    localparam logic [3:0]       BURST_MAX = 4'(BURST);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ISSUE     = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;

    logic [1:0]        state_q,     state_d;
    logic              has_token_q, has_token_d;
    logic [PTR_W-1:0]  rr_ptr_q,    rr_ptr_d;
    logic [3:0]        burst_cnt_q, burst_cnt_d;
    logic [PTR_W-1:0]  gnt_idx_q,   gnt_idx_d;
    logic [DATA_W-1:0] tx_data_q,   tx_data_d;
    logic              tx_valid_q,  tx_valid_d;
    logic [NREQ-1:0]   req_grant_q, req_grant_d;
    logic [NREQ-1:0]   req_done_q,  req_done_d;
    logic              token_out_q, token_out_d;
    logic              token_dup_q, token_dup_d;

    logic              token_rel;
    logic              win_found;
    logic [PTR_W-1:0]  win_idx;
    logic [PTR_W-1:0]  cand_idx;
    int unsigned       cand;

    // First pending request at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand     = (32'(rr_ptr_q) + i) % NREQ;
            cand_idx = PTR_W'(cand);
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        has_token_d = has_token_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        gnt_idx_d   = gnt_idx_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        req_grant_d = '0;
        req_done_d  = '0;
        token_out_d = 1'b0;
        token_dup_d = 1'b0;
        token_rel   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (has_token_q) begin
                    if (!win_found || burst_cnt_q == BURST_MAX) begin
                        token_rel   = 1'b1;
                        token_out_d = 1'b1;
                        burst_cnt_d = '0;
                    end else if (tx.TX_Ready) begin
                        gnt_idx_d            = win_idx;
                        tx_data_d            = req_data[32'(win_idx)*DATA_W +: DATA_W];
                        tx_valid_d           = 1'b1;
                        req_grant_d[win_idx] = 1'b1;
                        state_d              = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (!tx.TX_Ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (tx.TX_Ready) begin
                    req_done_d[gnt_idx_q] = 1'b1;
                    rr_ptr_d    = (gnt_idx_q == LAST_IDX) ? '0 : gnt_idx_q + 1'b1;
                    burst_cnt_d = burst_cnt_q + 4'd1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A token arriving on the release cycle is the token coming straight back.
        if (token_in) begin
            has_token_d = 1'b1;
            token_dup_d = has_token_q && !token_rel;
        end else if (token_rel) begin
            has_token_d = 1'b0;
        end
    end

    always_ff @(posedge Clk_S or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= S_IDLE;
            has_token_q <= (INIT_TOKEN != 0);
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            gnt_idx_q   <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            req_grant_q <= '0;
            req_done_q  <= '0;
            token_out_q <= 1'b0;
            token_dup_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            has_token_q <= has_token_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            gnt_idx_q   <= gnt_idx_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            req_grant_q <= req_grant_d;
            req_done_q  <= req_done_d;
            token_out_q <= token_out_d;
            token_dup_q <= token_dup_d;
        end
    end

    assign req_grant        = req_grant_q;
    assign req_done         = req_done_q;
    assign token_out        = token_out_q;
    assign token_dup        = token_dup_q;
    assign tx.TX_Data       = tx_data_q;
    assign tx.TX_Data_Valid = tx_valid_q;
endmodule
